// File: rtl/sid_i2s_tx_pkg.sv
// Shared types and frame geometry for the SID I2S output stage.
package sid_i2s_tx_pkg;

    typedef logic signed [23:0] s24_t;

    typedef struct packed {
        s24_t left;
        s24_t right;
    } audio_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} i2s_state_t;

    localparam int I2S_SLOT_BITS  = 32;
    localparam int I2S_FRAME_BITS = 64;
    localparam int I2S_PAD_BITS   = I2S_SLOT_BITS - $bits(s24_t);

    // Left then right, each sample MSB-aligned in its slot with zero padding below.
    function automatic logic [I2S_FRAME_BITS-1:0] i2s_frame(input audio_t a);
        return {a.left, {I2S_PAD_BITS{1'b0}}, a.right, {I2S_PAD_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/sid_i2s_tx.sv
// Master-mode Philips I2S transmitter for the SID stereo pair, with a one-deep
// sample-and-hold buffer that decouples the SID update rate from the frame rate.
module sid_i2s_tx
    import sid_i2s_tx_pkg::*;
#(
    parameter int SCK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] audio_i,
    input  logic        audio_valid,
    input  logic        enable,
    output logic        i2s_sck,
    output logic        i2s_ws,
    output logic        i2s_sd,
    output logic        frame_start,
    output logic        underrun
);

    localparam int CNT_W = $clog2(I2S_FRAME_BITS);
    localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = '1;
    localparam logic [CNT_W-1:0] SLOT_EDGE = CNT_W'(I2S_SLOT_BITS);

    i2s_state_t                state, state_nxt;
    logic [DIV_W-1:0]          div;
    logic [CNT_W-1:0]          bit_cnt, bit_nxt, bit_ahead;
    logic [I2S_FRAME_BITS-1:0] shift, frame;
    audio_t                    hold;
    logic                      fresh, primed;
    logic                      tick, fall, wrap, stop, load, ws_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (!enable) state_nxt = DRAIN;
            DRAIN:   if (stop) state_nxt = IDLE;
                     else if (enable) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // WS leads the slot MSB by one bit: it reflects the slot of the bit after next.
    always_comb begin
        tick      = (div == DIV_LAST);
        fall      = (state != IDLE) && tick && i2s_sck;
        bit_nxt   = bit_cnt + CNT_ONE;
        bit_ahead = bit_nxt + CNT_ONE;
        ws_nxt    = (bit_ahead >= SLOT_EDGE);
        wrap      = fall && (bit_nxt == '0);
        stop      = wrap && (state == DRAIN) && !enable;
        load      = wrap && !stop;
        frame     = i2s_frame(audio_valid ? audio_t'(audio_i) : hold);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i2s_sck     <= 1'b0;
            i2s_ws      <= 1'b1;
            i2s_sd      <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            div         <= '0;
            bit_cnt     <= CNT_LAST;
            shift       <= '0;
            hold        <= '0;
            fresh       <= 1'b0;
            primed      <= 1'b0;
        end else begin
            frame_start <= load;
            // A strobe coinciding with the load bypasses the hold, so it is never stale.
            underrun    <= load && !audio_valid && !fresh && primed;

            if (audio_valid) hold <= audio_t'(audio_i);
            if (load)             fresh <= 1'b0;
            else if (audio_valid) fresh <= 1'b1;
            if (load) primed <= 1'b1;

            if ((state == IDLE) || stop) begin
                i2s_sck <= 1'b0;
                i2s_sd  <= 1'b0;
                i2s_ws  <= !((state == IDLE) && enable);
                div     <= '0;
                bit_cnt <= CNT_LAST;
            end else begin
                div <= tick ? '0 : div + DIV_ONE;
                if (tick) i2s_sck <= !i2s_sck;
                if (fall) begin
                    bit_cnt <= bit_nxt;
                    i2s_ws  <= ws_nxt;
                    if (load) begin
                        shift  <= frame;
                        i2s_sd <= frame[I2S_FRAME_BITS-1];
                    end else begin
                        shift  <= shift << 1;
                        i2s_sd <= shift[I2S_FRAME_BITS-2];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sid_i2s_tx.sv
// Directed bench for sid_i2s_tx: expected frames are queued as stimulus is
// driven and compared bit-by-bit as the DUT serialises them.
module tb_sid_i2s_tx;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b0;
    logic [47:0] audio_i     = '0;
    logic        audio_valid = 1'b0;
    logic        enable      = 1'b0;
    logic        i2s_sck, i2s_ws, i2s_sd, frame_start, underrun;

    typedef struct {
        logic [63:0] data;
        logic        ur;
    } exp_t;

    localparam logic [63:0] WS_PATTERN = 64'h0000_0001_FFFF_FFFE;

    exp_t        exp_q[$];
    exp_t        cur;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          fs_count = 0;
    int          frames_done = 0;
    int          bit_idx = 0;
    logic        in_frame = 1'b0;
    logic        sck_prev = 1'b0;
    logic [63:0] sd_word = '0;
    logic [63:0] ws_word = '0;

    sid_i2s_tx #(.SCK_DIV(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .audio_i     (audio_i),
        .audio_valid (audio_valid),
        .enable      (enable),
        .i2s_sck     (i2s_sck),
        .i2s_ws      (i2s_ws),
        .i2s_sd      (i2s_sd),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_pair(input logic [47:0] p, input logic ur);
        exp_t e;
        e.data = {p[47:24], 8'h00, p[23:0], 8'h00};
        e.ur   = ur;
        exp_q.push_back(e);
    endtask

    task automatic strobe(input logic [47:0] p);
        audio_i     = p;
        audio_valid = 1'b1;
        @(negedge clk);
        audio_valid = 1'b0;
    endtask

    task automatic wait_fs(output int at);
        int n;
        n = 0;
        @(negedge clk);
        while (frame_start !== 1'b1 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        chk_bit("frame_start_seen", frame_start, 1'b1);
        at = cyc;
    endtask

    task automatic wait_sck(input logic level);
        int n;
        n = 0;
        while (i2s_sck !== level && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk_bit("sck_reach", i2s_sck, level);
    endtask

    task automatic mon_step();
        if (!rst_n) begin
            in_frame = 1'b0;
            sck_prev = 1'b0;
        end else begin
            if (frame_start === 1'b1) begin
                fs_count++;
                chk_int("frame_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    chk_bit("frame_underrun", underrun, cur.ur);
                    in_frame = 1'b1;
                    bit_idx  = 0;
                    sd_word  = '0;
                    ws_word  = '0;
                end
            end else if (underrun === 1'b1) begin
                chk_bit("underrun_only_on_load", frame_start, 1'b1);
            end
            if (in_frame && i2s_sck === 1'b1 && sck_prev === 1'b0) begin
                sd_word = {sd_word[62:0], i2s_sd};
                ws_word = {ws_word[62:0], i2s_ws};
                bit_idx++;
                if (bit_idx == 64) begin
                    in_frame = 1'b0;
                    frames_done++;
                    chk_word("frame_sd", sd_word, cur.data);
                    chk_word("frame_ws", ws_word, WS_PATTERN);
                end
            end
            sck_prev = i2s_sck;
        end
    endtask

    initial begin
        int   t_a, t_b, c0, n0, r1, r2;
        logic seen;

        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        // Reset and idle
        repeat (3) @(negedge clk);
        chk_bit("rst_sck", i2s_sck, 1'b0);
        chk_bit("rst_ws", i2s_ws, 1'b1);
        chk_bit("rst_sd", i2s_sd, 1'b0);
        chk_bit("rst_fs", frame_start, 1'b0);
        chk_bit("rst_ur", underrun, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk_bit("idle_sck", i2s_sck, 1'b0);
        chk_bit("idle_ws", i2s_ws, 1'b1);
        chk_bit("idle_fs", frame_start, 1'b0);

        // Free running with no samples: zeros, underrun from the second frame
        push_pair(48'h0, 1'b0);
        c0 = cyc;
        enable = 1'b1;
        wait_fs(t_a);
        chk_int("first_fs_latency", t_a - c0, 9);
        push_pair(48'h0, 1'b1);
        wait_fs(t_b);
        chk_int("frame_period", t_b - t_a, 512);
        wait_sck(1'b1);
        r1 = cyc;
        wait_sck(1'b0);
        wait_sck(1'b1);
        r2 = cyc;
        chk_int("sck_period", r2 - r1, 8);

        // Extreme values through the hold buffer
        push_pair({24'h800001, 24'h7FFFFE}, 1'b0);
        strobe({24'h800001, 24'h7FFFFE});
        wait_fs(t_a);

        // Newest of two strobes wins
        push_pair({24'hABCDEF, 24'hFEDCBA}, 1'b0);
        strobe({24'h123456, 24'h654321});
        repeat (5) @(negedge clk);
        strobe({24'hABCDEF, 24'hFEDCBA});
        wait_fs(t_b);
        chk_int("frame_period_2", t_b - t_a, 512);

        // Strobe in the exact load clock bypasses the hold
        push_pair({24'h00000F, 24'hF00000}, 1'b0);
        repeat (511) @(negedge clk);
        audio_i     = {24'h00000F, 24'hF00000};
        audio_valid = 1'b1;
        @(negedge clk);
        audio_valid = 1'b0;
        chk_bit("bypass_fs", frame_start, 1'b1);
        chk_bit("bypass_ur", underrun, 1'b0);
        t_a = cyc;
        chk_int("bypass_align", t_a - t_b, 512);
        push_pair({24'h00000F, 24'hF00000}, 1'b1);
        wait_fs(t_b);

        // Drop enable at bit 10: frame completes, then idle with no extra load
        repeat (84) @(negedge clk);
        enable = 1'b0;
        n0 = fs_count;
        repeat (600) @(negedge clk);
        chk_int("drain_no_extra_fs", fs_count, n0);
        chk_bit("drain_idle_sck", i2s_sck, 1'b0);
        chk_bit("drain_idle_ws", i2s_ws, 1'b1);
        chk_bit("drain_idle_sd", i2s_sd, 1'b0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (i2s_sck !== 1'b0) seen = 1'b1;
        end
        chk_bit("idle_sck_quiet", seen, 1'b0);

        // Restart from idle, then a drain excursion that is cancelled mid-frame
        push_pair({24'h00000F, 24'hF00000}, 1'b1);
        c0 = cyc;
        enable = 1'b1;
        wait_fs(t_a);
        chk_int("reenable_latency", t_a - c0, 9);
        repeat (84) @(negedge clk);
        enable = 1'b0;
        repeat (100) @(negedge clk);
        enable = 1'b1;
        push_pair({24'hFFFFFF, 24'hFFFFFF}, 1'b0);
        strobe({24'hFFFFFF, 24'hFFFFFF});
        wait_fs(t_b);
        chk_int("drain_resume_period", t_b - t_a, 512);

        // Asynchronous reset at bit 40, between clock edges
        repeat (325) @(negedge clk);
        chk_bit("pre_rst_sck", i2s_sck, 1'b1);
        chk_bit("pre_rst_sd", i2s_sd, 1'b1);
        chk_bit("pre_rst_ws", i2s_ws, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_bit("async_rst_sck", i2s_sck, 1'b0);
        chk_bit("async_rst_ws", i2s_ws, 1'b1);
        chk_bit("async_rst_sd", i2s_sd, 1'b0);
        chk_bit("async_rst_fs", frame_start, 1'b0);
        chk_bit("async_rst_ur", underrun, 1'b0);
        repeat (3) @(negedge clk);
        push_pair(48'h0, 1'b0);
        c0 = cyc;
        rst_n = 1'b1;
        wait_fs(t_a);
        chk_int("post_rst_latency", t_a - c0, 9);

        // Let the last frame finish and wind down
        enable = 1'b0;
        repeat (600) @(negedge clk);
        chk_bit("end_idle_ws", i2s_ws, 1'b1);
        chk_int("queue_empty", exp_q.size(), 0);
        chk_int("frames_done", frames_done, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
